// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with flag-qualified branch resolution
module pc_sequencer #(
   parameter int                    ADDR_WIDTH = 12,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  pc_valid,
   input  logic                  pc_ready,
   input  logic                  flags_we,
   input  logic [3:0]            flags_in,
   input  logic                  flags_busy,
   input  logic                  br_req,
   input  logic                  br_uncond,
   input  logic [2:0]            br_cond,
   input  logic [ADDR_WIDTH-1:0] br_target,
   output logic                  br_ack,
   output logic                  br_taken,
   output logic                  flush,
   input  logic                  halt,
   output logic                  halted
);

   localparam logic [1:0] ST_RUN        = 2'd0;
   localparam logic [1:0] ST_WAIT_FLAGS = 2'd1;
   localparam logic [1:0] ST_REDIRECT   = 2'd2;
   localparam logic [1:0] ST_HALT       = 2'd3;

   localparam logic [2:0] COND_ZERO             = 3'd0;
   localparam logic [2:0] COND_NOT_ZERO         = 3'd1;
   localparam logic [2:0] COND_POSITIVE         = 3'd2;
   localparam logic [2:0] COND_NEGATIVE         = 3'd3;
   localparam logic [2:0] COND_CARRY_SET        = 3'd4;
   localparam logic [2:0] COND_CARRY_CLEARED    = 3'd5;
   localparam logic [2:0] COND_OVERFLOW_SET     = 3'd6;
   localparam logic [2:0] COND_OVERFLOW_CLEARED = 3'd7;

   logic [1:0]            r_state;
   logic [1:0]            w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_pc;
   logic [ADDR_WIDTH-1:0] w_pc_nxt;
   logic [ADDR_WIDTH-1:0] w_pc_inc;
   logic [3:0]            r_flags;
   logic [3:0]            w_eff_flags;
   logic                  w_z, w_n, w_c, w_v;
   logic                  w_cond_true;
   logic                  w_fetch;
   logic                  w_run_resolvable;
   logic                  w_resolve;
   logic                  w_take;

   // Flags written this cycle are visible to the branch immediately (bypass).
   assign w_eff_flags = flags_we ? flags_in : r_flags;
   assign w_z = w_eff_flags[3];
   assign w_n = w_eff_flags[2];
   assign w_c = w_eff_flags[1];
   assign w_v = w_eff_flags[0];

   always_comb begin
      w_cond_true = 1'b0;
      case (br_cond)
         COND_ZERO:             w_cond_true = w_z;
         COND_NOT_ZERO:         w_cond_true = !w_z;
         COND_POSITIVE:         w_cond_true = !w_n && !w_z;
         COND_NEGATIVE:         w_cond_true = w_n;
         COND_CARRY_SET:        w_cond_true = w_c;
         COND_CARRY_CLEARED:    w_cond_true = !w_c;
         COND_OVERFLOW_SET:     w_cond_true = w_v;
         COND_OVERFLOW_CLEARED: w_cond_true = !w_v;
         default:               w_cond_true = 1'b0;
      endcase
   end

   assign w_fetch          = (r_state == ST_RUN) && pc_ready;
   assign w_run_resolvable = br_req && (br_uncond || !flags_busy || flags_we);
   assign w_pc_inc         = r_pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   always_comb begin
      w_resolve = 1'b0;
      case (r_state)
         ST_RUN:        w_resolve = w_run_resolvable;
         ST_WAIT_FLAGS: w_resolve = br_req && flags_we;
         default:       w_resolve = 1'b0;
      endcase
   end

   assign w_take = w_resolve && (br_uncond || w_cond_true);

   // A resolving branch outranks halt; halt is only honoured from RUN.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN: begin
            if (w_take)
               w_state_nxt = ST_REDIRECT;
            else if (w_resolve)
               w_state_nxt = ST_RUN;
            else if (halt)
               w_state_nxt = ST_HALT;
            else if (br_req)
               w_state_nxt = ST_WAIT_FLAGS;
            else
               w_state_nxt = ST_RUN;
         end
         ST_WAIT_FLAGS: begin
            if (w_take)
               w_state_nxt = ST_REDIRECT;
            else if (w_resolve)
               w_state_nxt = ST_RUN;
            else
               w_state_nxt = ST_WAIT_FLAGS;
         end
         ST_REDIRECT: w_state_nxt = ST_RUN;
         ST_HALT:     w_state_nxt = halt ? ST_HALT : ST_RUN;
         default:     w_state_nxt = ST_RUN;
      endcase
   end

   always_comb begin
      w_pc_nxt = r_pc;
      if (w_take)
         w_pc_nxt = br_target;
      else if (w_fetch)
         w_pc_nxt = w_pc_inc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_RUN;
         r_pc    <= RESET_PC;
         r_flags <= 4'b0000;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         if (flags_we)
            r_flags <= flags_in;
      end
   end

   // Pulses are gated by rst_n so a branch held across reset never acks.
   assign pc       = r_pc;
   assign pc_valid = (r_state == ST_RUN);
   assign halted   = (r_state == ST_HALT);
   assign br_ack   = w_resolve && rst_n;
   assign br_taken = w_take && rst_n;
   assign flush    = w_take && rst_n;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: program counter width in bits.
REQ-002 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 pc  output  ADDR_WIDTH  current fetch address.
REQ-006 pc_valid  output  1  pc is a valid fetch address this cycle.
REQ-007 pc_ready  input  1  fetch consumer accepts pc; a fetch occurs when pc_valid && pc_ready.
REQ-008 flags_we  input  1  write enable for the internal Z/N/C/V flag register.
REQ-009 flags_in  input  4  {Z,N,C,V} from the ALU.
REQ-010 flags_busy  input  1  an ALU op that will write flags is still in flight.
REQ-011 br_req  input  1  branch request, held until br_ack.
REQ-012 br_uncond  input  1  branch is unconditional; br_cond is ignored.
REQ-013 br_cond  input  3  branch_condition_e from program_counter_pkg.
REQ-014 br_target  input  ADDR_WIDTH  branch destination, stable while br_req is high.
REQ-015 br_ack  output  1  one-cycle pulse: branch resolved.
REQ-016 br_taken  output  1  qualifies br_ack: 1 = taken, 0 = not taken.
REQ-017 flush  output  1  one-cycle pulse: discard in-flight fetches.
REQ-018 halt  input  1  level; request to stop fetching.
REQ-019 halted  output  1  sequencer is in HALT.

Function
REQ-020 The FSM SHALL have four states: RUN, WAIT_FLAGS, REDIRECT, HALT.
REQ-021 In RUN: pc_valid = 1; on a fetch, pc <= pc + 1, mod 2^ADDR_WIDTH (all-ones wraps to 0).
REQ-022 Condition evaluation SHALL be combinational on the effective flags: flags_in when flags_we = 1, otherwise the flag register.
REQ-023 Condition decode: ZERO=Z, NOT_ZERO=!Z, POSITIVE=!N&&!Z, NEGATIVE=N, CARRY_SET=C, CARRY_CLEARED=!C, OVERFLOW_SET=V, OVERFLOW_CLEARED=!V; br_uncond forces taken.
REQ-024 RUN with br_req && (br_uncond || !flags_busy || flags_we): resolve in the same cycle.
  - br_ack = 1 and br_taken = the result.
  - Taken: pc <= br_target, flush = 1, next state REDIRECT; a fetch accepted that cycle does not increment pc.
  - Not taken: stay in RUN; normal increment rules apply.
REQ-025 RUN with a conditional br_req && flags_busy && !flags_we: next state WAIT_FLAGS, pc_valid = 0 from the next cycle.
REQ-026 WAIT_FLAGS: pc_valid = 0. When flags_we = 1, resolve per REQ-024 using flags_in; a not-taken branch returns to RUN.
REQ-027 REDIRECT: lasts exactly one cycle with pc_valid = 0 and pc = br_target, then RUN.
REQ-028 halt = 1 in RUN with no branch resolving: next state HALT.
REQ-029 A resolving branch SHALL take priority over halt; halt is sampled again in the following state.
REQ-030 halt = 1 in WAIT_FLAGS or REDIRECT: deferred until the state returns to RUN.
REQ-031 HALT: pc_valid = 0, halted = 1, pc held, br_req ignored (no br_ack). When halt = 0, next state RUN.
REQ-032 The flag register SHALL update whenever flags_we = 1, in every state.
REQ-033 br_ack SHALL never assert on two consecutive cycles for the same request; the requester deasserts br_req in the cycle after br_ack.

Reset
REQ-034 While rst_n = 0 (asynchronous), and on release:
  - pc = RESET_PC, state = RUN, pc_valid = 1;
  - flag register = 4'b0000;
  - br_ack = 0, br_taken = 0, flush = 0, halted = 0.
REQ-035 Reset asserted mid-operation (including in WAIT_FLAGS or HALT) SHALL abandon any pending branch with no br_ack.

Verification
REQ-036 Reset, then pc_ready = 1 for 3 cycles -> pc goes 0, 1, 2, 3; pc_valid = 1 throughout.
REQ-037 ADDR_WIDTH = 4, pc = 15, fetch -> pc = 0.
REQ-038 Flags Z = 1, br_req with COND_ZERO, target 0x40 -> same-cycle br_ack = 1, br_taken = 1, flush = 1; next cycle pc = 0x40, pc_valid = 0; the cycle after, pc_valid = 1.
REQ-039 flags_busy = 1 with br_req COND_CARRY_SET; 2 cycles later flags_we = 1 with C = 0 -> pc_valid = 0 while waiting; br_ack = 1, br_taken = 0 on the flags_we cycle; then RUN with pc unchanged.
REQ-040 halt and a taken unconditional branch in the same cycle -> branch taken first, REDIRECT, then HALT with pc = target and halted = 1; halt = 0 -> resume fetch at the target.
REQ-041 rst_n pulsed low in WAIT_FLAGS -> pc = RESET_PC immediately, no br_ack, flags = 0.
